pulse_seq_cpmg: RTL and testbench
=================================

Name: pulse_seq_cpmg

Overview:
Parametrised successor to the single-shot Hahn/CPMG pulse generator. It drives the scope trigger, the pulse switch and the block (inhibit) switch for one pump pulse followed by up to 2^NW-1 pi pulses, each with its own receive window, plus a CW mode. Timing configuration is captured in shadow registers at period boundaries through a valid/ack handshake, so mid-period changes never corrupt a sequence. It sits between the UART/config register file and the FPGA output pins.

Parameters:
CW, 32, absolute cycle-counter width
TW, 16, width of the p1width/delay/p2width/blk_width fields
NW, 8, width of the pi-pulse count
PW, 8, width of the coarse period field
PER_SHIFT, 16, left-shift applied to the period field
DEF_P1, 30, default p1width after reset (150 ns at about 5 ns/cycle)
DEF_DLY, 200, default delay
DEF_P2, 30, default p2width
DEF_PB, 50, default blk_start
DEF_BW, 100, default blk_width
DEF_N, 1, default cpmg count

Ports:
clk_pll  in  1  200 MHz PLL clock; the only clock
reset  in  1  synchronous, active-high reset
cfg_valid  in  1  new configuration present on the cfg inputs
cfg_ack  out  1  one-cycle strobe: configuration captured into the shadow registers
pump  in  1  first (pump) pulse enabled
period  in  PW  period length field
p1width  in  TW  pump-pulse width, in cycles
delay  in  TW  tau, in cycles
p2width  in  TW  pi-pulse width, in cycles
cpmg  in  NW  number of pi pulses; 0 selects CW mode
blk_start  in  TW  cycles from the end of a pi pulse to the window opening
blk_width  in  TW  receive-window width, in cycles
block  in  1  blocking enabled
run  in  1  sequencer enable, sampled at period boundaries
sync_on  out  1  scope trigger
pulse_on  out  1  pulse-switch drive
inhib  out  1  block-switch drive (1 = blocked)
pi_count  out  NW  number of pi pulses completed in the current period
seq_done  out  1  one-cycle strobe when the last receive window closes

Behaviour:
- Reset (synchronous) state:
  - All outputs are 0.
  - The counter is 0 and the FSM is in IDLE.
  - The shadow registers load the DEF_* values, with pump=1, block=1 and period=1.
- Period: P = (period << PER_SHIFT) + 1 cycles; a period field of 0 is treated as 1. The counter runs 0..P-1 and then wraps to 0.
- Boundary (counter==P-1):
  - If cfg_valid=1, the shadow registers load all cfg inputs and cfg_ack pulses on the next cycle.
  - run is sampled here. If run=0, the next period stays in IDLE with all outputs 0.
- Output timing:
  - All outputs are registered.
  - "High over [a,b)" means the output is high in cycle n+1 for every counter value n in [a,b).
- Pulsed mode (N = cpmg ≥ 1):
  - Pi pulse k (k = 0..N-1) starts at S_k = p1 + d + k*(2d + p2).
  - Receive window k opens at E_k = S_k + p2 + pb.
  - pulse_on is high over [0,p1) when pump=1, and over [S_k, S_k+p2) for each k.
  - sync_on is high over [0, S_0+p2).
  - inhib equals block everywhere except over [E_k, E_k+bw), where it is 0.
  - pi_count increments when window k closes.
  - seq_done pulses when window N-1 closes.
- CW mode (cpmg = 0):
  - pulse_on is 1 and inhib is 0 for the whole period.
  - sync_on is high over [0,p1); p1=0 is treated as 1.
  - pi_count stays 0 and seq_done is never raised.
- FSM states and transitions:
  - IDLE → P1 → TAU1 → PI → PB_WAIT → WIN → TAU2.
  - From TAU2 the FSM returns to PI while k<N, otherwise it goes to HOLD.
  - CW mode uses a single CW state.
  - HOLD → IDLE at the period wrap.
- Zero widths: a zero-length state is skipped in the same cycle. p2=0 produces no pi pulse but timing still advances; bw=0 produces no window, yet pi_count and seq_done still occur.
- Window/pulse overlap: when pb+bw > 2d, the start of the next pi pulse closes the window early, forcing inhib=block.
- Period truncation: events that fall at or beyond P are dropped. At the wrap, all outputs return to their counter=0 values and the shadow registers apply.
- Arithmetic: event times accumulate in CW bits and wrap modulo 2^CW. The configuration must keep event times below 2^CW.
- Reset mid-period: the next cycle shows reset values, and after release the counter restarts from 0.

Decomposition:
- pulse_seq_pkg holds:
  - the FSM state enum;
  - the CW/TW/NW width constants;
  - the DEF_* defaults;
  - a cfg struct containing pump, period, p1, d, p2, N, pb, bw and block.
- Sub-module pulse_cfg_shadow holds the shadow-register bank, the boundary-gated capture and cfg_ack generation.

Test Plan:
- Hahn: p1=30, d=200, p2=30, N=1, pb=50, bw=100, block=1, period=1 →
  - pulse_on high over [0,30) and [230,260);
  - sync_on high over [0,260);
  - inhib low over [310,410);
  - seq_done at counter 409 + 1.
- CPMG: N=3, otherwise as the Hahn case →
  - pi pulses start at 230, 660 and 1090;
  - windows at [310,410), [740,840) and [1170,1270);
  - pi_count counts 1, 2, 3.
- CW: cpmg=0, p1=30 →
  - pulse_on=1 and inhib=0 for all 65537 cycles;
  - sync_on high for 30 cycles per period.
- Config handshake: cfg_valid asserted at counter 5000 with d=100 →
  - the current period is unchanged (pi pulse at 230);
  - cfg_ack pulses once after the wrap;
  - the next period's pi pulse is at 130.
- Corners:
  - block=0 → inhib=0 throughout;
  - pb=500 with 2d=400 → window 0 truncated at S_1;
  - bw=0 → inhib never drops and seq_done still occurs.
- Reset at counter 700 → all outputs 0 on the next cycle; after release, DEF timing resumes from counter 0.

Source files
------------

// File: rtl/pulse_seq_pkg.sv
// Shared widths, defaults, FSM states and the configuration payload for the CPMG pulse sequencer.
package pulse_seq_pkg;

    localparam int unsigned CW = 32;
    localparam int unsigned TW = 16;
    localparam int unsigned NW = 8;
    localparam int unsigned PW = 8;

    localparam int unsigned DEF_P1  = 30;
    localparam int unsigned DEF_DLY = 200;
    localparam int unsigned DEF_P2  = 30;
    localparam int unsigned DEF_PB  = 50;
    localparam int unsigned DEF_BW  = 100;
    localparam int unsigned DEF_N   = 1;

    typedef enum logic [3:0] {
        S_IDLE, S_P1, S_TAU1, S_PI, S_PB_WAIT, S_WIN, S_TAU2, S_HOLD, S_CW
    } state_t;

    typedef struct packed {
        logic          pump;
        logic [PW-1:0] period;
        logic [TW-1:0] p1;
        logic [TW-1:0] d;
        logic [TW-1:0] p2;
        logic [NW-1:0] n;
        logic [TW-1:0] pb;
        logic [TW-1:0] bw;
        logic          block;
    } cfg_t;

    localparam cfg_t CFG_DEF = '{
        pump:   1'b1,
        period: PW'(1),
        p1:     TW'(DEF_P1),
        d:      TW'(DEF_DLY),
        p2:     TW'(DEF_P2),
        n:      NW'(DEF_N),
        pb:     TW'(DEF_PB),
        bw:     TW'(DEF_BW),
        block:  1'b1
    };

endpackage

// File: rtl/pulse_seq_cpmg_if.sv
// Configuration bus between the register file (master) and the pulse sequencer (slave).
interface pulse_seq_cpmg_if;
    import pulse_seq_pkg::*;

    logic          cfg_valid;
    logic          cfg_ack;
    logic          pump;
    logic [PW-1:0] period;
    logic [TW-1:0] p1width;
    logic [TW-1:0] delay;
    logic [TW-1:0] p2width;
    logic [NW-1:0] cpmg;
    logic [TW-1:0] blk_start;
    logic [TW-1:0] blk_width;
    logic          block;
    logic          run;

    modport master (
        output cfg_valid, pump, period, p1width, delay, p2width, cpmg,
               blk_start, blk_width, block, run,
        input  cfg_ack
    );

    modport slave (
        input  cfg_valid, pump, period, p1width, delay, p2width, cpmg,
               blk_start, blk_width, block, run,
        output cfg_ack
    );

endinterface

// File: rtl/pulse_cfg_shadow.sv
// Shadow configuration bank: captures the live cfg only at a period boundary and acknowledges it.
module pulse_cfg_shadow
    import pulse_seq_pkg::*;
(
    input  logic clk_pll,
    input  logic reset,
    input  logic boundary,
    input  logic cfg_valid,
    input  cfg_t cfg_in,
    output cfg_t cfg,
    output logic cfg_ack
);

    always_ff @(posedge clk_pll) begin
        if (reset) begin
            cfg     <= CFG_DEF;
            cfg_ack <= 1'b0;
        end else begin
            cfg_ack <= boundary && cfg_valid;
            if (boundary && cfg_valid) begin
                cfg <= cfg_in;
            end
        end
    end

endmodule

// File: rtl/pulse_seq_cpmg.sv
// Hahn/CPMG pulse sequencer: pump pulse, N pi pulses with receive windows, or CW, over a fixed period.
module pulse_seq_cpmg
    import pulse_seq_pkg::*;
#(
    parameter int unsigned PER_SHIFT = 16
) (
    input  logic             clk_pll,
    input  logic             reset,
    pulse_seq_cpmg_if.slave  bus,
    output logic             sync_on,
    output logic             pulse_on,
    output logic             inhib,
    output logic [NW-1:0]    pi_count,
    output logic             seq_done
);

    cfg_t          cfg;
    cfg_t          cfg_in;
    state_t        state;
    state_t        phase_c;
    logic [CW-1:0] cnt;
    logic [CW-1:0] kacc;
    logic [NW-1:0] k;
    logic [NW-1:0] k_next_c;
    logic          active;
    logic          first;

    logic [PW-1:0] per_c;
    logic [CW-1:0] last_c, p1_c, d_c, p2_c, pb_c, bw_c;
    logic [CW-1:0] s_c, pend_c, e_c, wend_c, snext_c, close_c, sync_end_c, cw_end_c;
    logic          wrap_c, run_c, cw_c, pending_c, last_k_c, adv_c;
    logic          pulse_n, sync_n, inhib_n;

    always_comb begin
        cfg_in        = '0;
        cfg_in.pump   = bus.pump;
        cfg_in.period = bus.period;
        cfg_in.p1     = bus.p1width;
        cfg_in.d      = bus.delay;
        cfg_in.p2     = bus.p2width;
        cfg_in.n      = bus.cpmg;
        cfg_in.pb     = bus.blk_start;
        cfg_in.bw     = bus.blk_width;
        cfg_in.block  = bus.block;
    end

    pulse_cfg_shadow u_shadow (
        .clk_pll   (clk_pll),
        .reset     (reset),
        .boundary  (wrap_c),
        .cfg_valid (bus.cfg_valid),
        .cfg_in    (cfg_in),
        .cfg       (cfg),
        .cfg_ack   (bus.cfg_ack)
    );

    // Event times of the current pi pulse k; kacc holds k*(2d+p2).
    always_comb begin
        per_c      = (cfg.period == '0) ? PW'(1) : cfg.period;
        last_c     = CW'(per_c) << PER_SHIFT;
        wrap_c     = (cnt == last_c);
        run_c      = first ? bus.run : active;
        cw_c       = (cfg.n == '0);
        p1_c       = CW'(cfg.p1);
        d_c        = CW'(cfg.d);
        p2_c       = CW'(cfg.p2);
        pb_c       = CW'(cfg.pb);
        bw_c       = CW'(cfg.bw);
        s_c        = p1_c + d_c + kacc;
        pend_c     = s_c + p2_c;
        e_c        = pend_c + pb_c;
        wend_c     = e_c + bw_c;
        snext_c    = s_c + (d_c << 1) + p2_c;
        sync_end_c = p1_c + d_c + p2_c;
        cw_end_c   = (cfg.p1 == '0) ? CW'(1) : p1_c;
        pending_c  = (k < cfg.n);
        last_k_c   = ({1'b0, k} + (NW+1)'(1)) == {1'b0, cfg.n};
        // A following pi pulse cuts the current window short.
        close_c    = (!last_k_c && (snext_c < wend_c)) ? snext_c : wend_c;
        adv_c      = run_c && !cw_c && pending_c && !wrap_c && ((cnt + CW'(1)) >= close_c);
        k_next_c   = wrap_c ? '0 : (adv_c ? k + NW'(1) : k);
    end

    always_comb begin
        phase_c = S_IDLE;
        pulse_n = 1'b0;
        sync_n  = 1'b0;
        inhib_n = 1'b0;
        if (!run_c) begin
            phase_c = S_IDLE;
        end else if (cw_c) begin
            phase_c = S_CW;
            pulse_n = 1'b1;
            sync_n  = (cnt < cw_end_c);
        end else begin
            sync_n  = (cnt < sync_end_c);
            pulse_n = cfg.pump && (cnt < p1_c);
            inhib_n = cfg.block;
            if (!pending_c || ((state == S_HOLD) && (cnt != '0))) begin
                phase_c = S_HOLD;
            end else if (cnt < p1_c) begin
                phase_c = S_P1;
            end else if (cnt < s_c) begin
                phase_c = (k == '0) ? S_TAU1 : S_TAU2;
            end else if (cnt < pend_c) begin
                phase_c = S_PI;
                pulse_n = 1'b1;
            end else if (cnt < e_c) begin
                phase_c = S_PB_WAIT;
            end else if (cnt < close_c) begin
                phase_c = S_WIN;
                inhib_n = 1'b0;
            end else begin
                phase_c = S_TAU2;
            end
        end
    end

    always_ff @(posedge clk_pll) begin
        if (reset) begin
            cnt      <= '0;
            kacc     <= '0;
            k        <= '0;
            active   <= 1'b0;
            first    <= 1'b1;
            state    <= S_IDLE;
            sync_on  <= 1'b0;
            pulse_on <= 1'b0;
            inhib    <= 1'b0;
            pi_count <= '0;
            seq_done <= 1'b0;
        end else begin
            first <= 1'b0;
            k     <= k_next_c;
            if (wrap_c || first) begin
                active <= bus.run;
            end
            if (wrap_c) begin
                cnt  <= '0;
                kacc <= '0;
            end else begin
                cnt <= cnt + CW'(1);
                if (adv_c) begin
                    kacc <= kacc + (d_c << 1) + p2_c;
                end
            end
            state    <= phase_c;
            sync_on  <= sync_n;
            pulse_on <= pulse_n;
            inhib    <= inhib_n;
            pi_count <= k_next_c;
            seq_done <= adv_c && last_k_c;
        end
    end

endmodule

// File: tb/tb_pulse_seq_cpmg.sv
// Directed and random periods of the CPMG sequencer checked cycle by cycle against an interval model.
module tb_pulse_seq_cpmg;
    import pulse_seq_pkg::*;

    localparam int PSH  = 11;
    localparam int MAXP = 2050;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sync_on, pulse_on, inhib, seq_done;
    logic [NW-1:0] pi_count;

    pulse_seq_cpmg_if bus ();

    pulse_seq_cpmg #(.PER_SHIFT(PSH)) dut (
        .clk_pll  (clk),
        .reset    (reset),
        .bus      (bus),
        .sync_on  (sync_on),
        .pulse_on (pulse_on),
        .inhib    (inhib),
        .pi_count (pi_count),
        .seq_done (seq_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    // Expected waveform indexed by observed cycle m (reflects counter m-1): bit0 pulse, bit1 sync, bit2 inhib, bit3 done.
    logic [3:0] eb [MAXP];
    int         ec [MAXP];
    int         pcur;

    task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s m=%0d got=%0d exp=%0d", tag, m, obs, want);
        end
    endtask

    function automatic cfg_t mk(input int pump, input int per, input int p1, input int d, input int p2,
                                input int n, input int pb, input int bw, input int blk);
        cfg_t c;
        c.pump = 1'(pump);   c.period = PW'(per); c.p1 = TW'(p1); c.d = TW'(d); c.p2 = TW'(p2);
        c.n    = NW'(n);     c.pb = TW'(pb);      c.bw = TW'(bw);  c.block = 1'(blk);
        return c;
    endfunction

    task automatic mark(input int bitn, input int a, input int b, input int p, input logic v);
        for (int n = (a < 0 ? 0 : a); n < b && n < p; n++) eb[n+1][bitn] = v;
    endtask

    task automatic build(input cfg_t c, input logic run);
        int p, p1, d, p2, nn, pb, bw, s, snext, e, cl;
        p  = ((c.period == 0 ? 1 : int'(c.period)) << PSH) + 1;
        p1 = int'(c.p1); d = int'(c.d); p2 = int'(c.p2); nn = int'(c.n); pb = int'(c.pb); bw = int'(c.bw);
        pcur = p;
        for (int m = 0; m <= p; m++) begin eb[m] = '0; ec[m] = 0; end
        if (run) begin
            if (nn == 0) begin
                mark(0, 0, p, p, 1'b1);
                mark(1, 0, (p1 == 0) ? 1 : p1, p, 1'b1);
            end else begin
                mark(2, 0, p, p, c.block);
                mark(1, 0, p1 + d + p2, p, 1'b1);
                if (c.pump) mark(0, 0, p1, p, 1'b1);
                for (int k = 0; k < nn; k++) begin
                    s     = p1 + d + k * (2 * d + p2);
                    snext = s + 2 * d + p2;
                    mark(0, s, s + p2, p, 1'b1);
                    e  = s + p2 + pb;
                    cl = e + bw;
                    if (k < nn - 1 && snext < cl) cl = snext;
                    mark(2, e, cl, p, 1'b0);
                    if (cl < p) begin
                        for (int m = cl; m < p; m++) ec[m]++;
                        if (k == nn - 1) eb[cl][3] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic drive(input cfg_t c, input logic run, input logic valid);
        bus.pump = c.pump;   bus.period = c.period; bus.p1width = c.p1; bus.delay = c.d;
        bus.p2width = c.p2;  bus.cpmg = c.n;        bus.blk_start = c.pb; bus.blk_width = c.bw;
        bus.block = c.block; bus.run = run;         bus.cfg_valid = valid;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pulse"}, 0, 32'(pulse_on), 0);
        chk({tag, "_sync"},  0, 32'(sync_on), 0);
        chk({tag, "_inhib"}, 0, 32'(inhib), 0);
        chk({tag, "_count"}, 0, 32'(pi_count), 0);
        chk({tag, "_done"},  0, 32'(seq_done), 0);
        chk({tag, "_ack"},   0, 32'(bus.cfg_ack), 0);
    endtask

    // Present a config at the boundary and wait (bounded) for its acknowledge.
    task automatic apply(input cfg_t c, input logic run);
        logic ok = 1'b0;
        drive(c, run, 1'b1);
        for (int i = 0; i < MAXP + 4; i++) begin
            @(negedge clk);
            if (bus.cfg_ack === 1'b1) begin ok = 1'b1; break; end
        end
        chk("cfg_ack_seen", 0, 32'(ok), 1);
        bus.cfg_valid = 1'b0;
        chk("pi_count_wrap", 0, 32'(pi_count), 0);
        chk("seq_done_wrap", 0, 32'(seq_done), 0);
    endtask

    task automatic check_period(input cfg_t c, input logic run, input int stop_at,
                                input bit pre, input cfg_t nc);
        build(c, run);
        for (int m = 1; m < pcur; m++) begin
            @(negedge clk);
            chk("pulse_on", m, 32'(pulse_on), 32'(eb[m][0]));
            chk("sync_on",  m, 32'(sync_on),  32'(eb[m][1]));
            chk("inhib",    m, 32'(inhib),    32'(eb[m][2]));
            chk("seq_done", m, 32'(seq_done), 32'(eb[m][3]));
            chk("pi_count", m, 32'(pi_count), 32'(ec[m]));
            chk("cfg_ack",  m, 32'(bus.cfg_ack), 0);
            if (pre && m == 1000) drive(nc, 1'b1, 1'b1);
            if (m == stop_at) break;
        end
    endtask

    initial begin
        cfg_t def, hahn, cpmg3, cw0, cw1, hd100, nblk, ovl, bw0, p20, nop, rc;

        def   = mk(1, 1, 30, 200, 30, 1, 50, 100, 1);
        hahn  = mk(1, 1, 30, 200, 30, 1, 50, 100, 1);
        cpmg3 = mk(1, 1, 30, 200, 30, 3, 50, 100, 1);
        cw0   = mk(1, 0, 30, 200, 30, 0, 50, 100, 1);
        cw1   = mk(0, 1, 0, 10, 5, 0, 5, 5, 1);
        hd100 = mk(1, 1, 30, 100, 30, 1, 50, 100, 1);
        nblk  = mk(1, 1, 30, 200, 30, 3, 50, 100, 0);
        ovl   = mk(1, 1, 30, 200, 30, 2, 500, 100, 1);
        bw0   = mk(1, 1, 30, 200, 30, 2, 50, 0, 1);
        p20   = mk(1, 1, 40, 100, 0, 2, 10, 50, 1);
        nop   = mk(0, 1, 25, 150, 20, 2, 30, 60, 1);

        drive(def, 1'b1, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        check_period(def, 1'b1, 0, 0, def);

        apply(hahn, 1'b1);  check_period(hahn, 1'b1, 0, 0, def);
        apply(cpmg3, 1'b1); check_period(cpmg3, 1'b1, 0, 0, def);
        apply(cw0, 1'b1);   check_period(cw0, 1'b1, 0, 0, def);
        apply(cw1, 1'b1);   check_period(cw1, 1'b1, 0, 0, def);
        apply(hahn, 1'b1);  check_period(hahn, 1'b1, 0, 1, hd100);
        apply(hd100, 1'b1); check_period(hd100, 1'b1, 0, 0, def);
        apply(nblk, 1'b1);  check_period(nblk, 1'b1, 0, 0, def);
        apply(ovl, 1'b1);   check_period(ovl, 1'b1, 0, 0, def);
        apply(bw0, 1'b1);   check_period(bw0, 1'b1, 0, 0, def);
        apply(p20, 1'b1);   check_period(p20, 1'b1, 0, 0, def);
        apply(nop, 1'b1);   check_period(nop, 1'b1, 0, 0, def);
        apply(cpmg3, 1'b0); check_period(cpmg3, 1'b0, 0, 0, def);

        for (int i = 0; i < 8; i++) begin
            rc = mk(int'($urandom_range(1, 0)), 1, int'($urandom_range(60, 1)), int'($urandom_range(150, 10)),
                    int'($urandom_range(40, 1)), int'($urandom_range(4, 0)), int'($urandom_range(300, 0)),
                    int'($urandom_range(200, 0)), int'($urandom_range(1, 0)));
            apply(rc, 1'b1);
            check_period(rc, 1'b1, 0, 0, def);
        end

        // Reset in the middle of a CPMG period, then defaults from counter 0.
        apply(cpmg3, 1'b1);
        check_period(cpmg3, 1'b1, 700, 0, def);
        drive(def, 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk_zero("midreset");
        reset = 1'b0;
        check_period(def, 1'b1, 0, 0, def);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
